dmem_block_mover: RTL and testbench
===================================

// Module: dmem_block_mover
// PURPOSE
//  Bus initiator that drives the 32x8 data memory port (MEMREAD/MEMWRITE/ADDRESS/
//  WRITE_DATA/READ_DATA). On START it reads LEN bytes from SRC upward and writes
//  each one to DST upward. The byte is written either unchanged (copy) or
//  two's-complement negated. Used for block init/copy without CPU load/store.
// PARAMETERS
//  ADDR_W     8   address width driven on MEM_ADDRESS
//  DATA_W     8   data width
//  MEM_DEPTH  32  valid address range 0..MEM_DEPTH-1; address arithmetic wraps modulo this
//  READ_LAT   1   cycles from MEM_READ/MEM_ADDRESS valid to MEM_RDATA valid (>=1)
// PORTS
//  CLK          in   1       rising-edge clock
//  RST          in   1       reset, asynchronous, active-high
//  START        in   1       1-cycle request, sampled in IDLE only
//  OP           in   1       0=copy, 1=negate (wdata = ~rdata+1), latched at START
//  SRC          in   ADDR_W  first source address, latched at START
//  DST          in   ADDR_W  first destination address, latched at START
//  LEN          in   ADDR_W  byte count, latched at START
//  BUSY         out  1       transfer in progress
//  DONE         out  1       1-cycle pulse on completion or rejection
//  ERR          out  1       1-cycle pulse with DONE when request rejected
//  MEM_READ     out  1       read strobe to data memory
//  MEM_WRITE    out  1       write strobe to data memory
//  MEM_ADDRESS  out  ADDR_W  memory address
//  MEM_WDATA    out  DATA_W  memory write data
//  MEM_RDATA    in   DATA_W  memory read data
// BEHAVIOUR
//  - Reset: all outputs 0, FSM=IDLE, counters/latches 0. Reset mid-transfer aborts
//    immediately: strobes drop asynchronously, no DONE, and the transfer does not resume.
//  - FSM: IDLE -> CHECK -> RD -> WR -> (RD | FIN) -> IDLE.
//  - IDLE: START=1 at an edge latches OP/SRC/DST/LEN. Next state is CHECK.
//    BUSY=1 from that edge.
//  - CHECK (1 cycle): SRC>=MEM_DEPTH or DST>=MEM_DEPTH or LEN>MEM_DEPTH -> FIN
//    with ERR. LEN=0 -> FIN, no memory access, ERR=0. Otherwise RD, i=0.
//  - RD (READ_LAT cycles): MEM_READ=1, MEM_ADDRESS=(SRC+i)%MEM_DEPTH, held stable.
//    MEM_RDATA is captured on the last RD edge.
//  - WR (1 cycle): MEM_WRITE=1, MEM_ADDRESS=(DST+i)%MEM_DEPTH.
//    MEM_WDATA = captured byte (OP=0) or ~byte+1 mod 2^DATA_W (OP=1).
//    i++. If i==LEN the next state is FIN; otherwise RD.
//  - FIN (1 cycle): DONE=1 (ERR=1 if rejected), BUSY=0 on exit.
//  - Per byte: READ_LAT+1 cycles. Full transfer: 1+LEN*(READ_LAT+1) cycles
//    from the START edge, plus the FIN cycle.
//  - MEM_READ and MEM_WRITE are never both 1. Both are 0 in IDLE/CHECK/FIN.
//    MEM_ADDRESS=0 and MEM_WDATA=0 whenever no strobe is active.
//  - START while BUSY is ignored (not queued).
//  - Ascending order, no overlap handling: if DST lies in (SRC, SRC+LEN),
//    already-written bytes are re-read (pattern replication is the intended behaviour).
//  - Negate of 0x80 yields 0x80. Negate of 0x00 yields 0x00.
//  - Wrap: SRC=30, LEN=4 reads 30,31,0,1.
// TESTING
//  Memory preload: mem[k]=k for k<16, mem[16+k]=(-k)&0xFF.
//  1) SRC=2,DST=20,LEN=3,OP=0,READ_LAT=1 -> mem[20..22]=02,03,04.
//     DONE exactly 7 cycles after the START edge. ERR=0.
//  2) SRC=5,DST=8,LEN=2,OP=1 -> mem[8]=FB, mem[9]=FA.
//     Strobe trace: R5,W8,R6,W9. MEM_READ&MEM_WRITE never both 1.
//  3) SRC=30,DST=0,LEN=4,OP=0 -> reads 30,31,0,1 (wrap).
//     Writes F2,F1,F2,F1 to mem[0..3]: mem[0] is written before address 0 is read.
//  4) LEN=0 -> DONE after 2 cycles, no strobes.
//     SRC=40 -> DONE+ERR, no strobes.
//     LEN=33 -> DONE+ERR, no strobes.
//  5) START pulsed again mid-transfer -> ignored. Only one DONE; results match a single run.
//  6) RST asserted during a WR cycle -> MEM_WRITE=0 and BUSY=0 at once, with no DONE.
//     A subsequent START runs normally from IDLE.
//     Also run test 1 with READ_LAT=3: same memory result, DONE 13 cycles after START.

Source files
------------

// File: rtl/dmem_block_mover.sv
// dmem_block_mover: memory-port initiator that copies or negates a block of bytes from SRC to DST
module dmem_block_mover #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 8,
  parameter int MEM_DEPTH = 32,
  parameter int READ_LAT  = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  input  logic              OP,
  input  logic [ADDR_W-1:0] SRC,
  input  logic [ADDR_W-1:0] DST,
  input  logic [ADDR_W-1:0] LEN,
  output logic              BUSY,
  output logic              DONE,
  output logic              ERR,
  output logic              MEM_READ,
  output logic              MEM_WRITE,
  output logic [ADDR_W-1:0] MEM_ADDRESS,
  output logic [DATA_W-1:0] MEM_WDATA,
  input  logic [DATA_W-1:0] MEM_RDATA
);
  localparam int CW = READ_LAT > 1 ? $clog2(READ_LAT) : 1;
  localparam logic [ADDR_W:0] DEPTH = (ADDR_W + 1)'(MEM_DEPTH);
  typedef enum logic [2:0] {IDLE, CHECK, RD, WR, FIN} state_t;
  state_t state, nxt;
  logic op_r, err_r, bad, last;
  logic [ADDR_W-1:0] src_r, dst_r, len_r, i;
  logic [CW-1:0] lat_cnt;
  logic [DATA_W-1:0] byte_r;
  logic [ADDR_W:0] rd_addr, wr_addr;
  assign bad = {1'b0, src_r} >= DEPTH || {1'b0, dst_r} >= DEPTH || {1'b0, len_r} > DEPTH;
  assign last = lat_cnt == CW'(READ_LAT - 1);
  // source and destination both walk upward and wrap around the memory
  assign rd_addr = ({1'b0, src_r} + {1'b0, i}) % DEPTH;
  assign wr_addr = ({1'b0, dst_r} + {1'b0, i}) % DEPTH;
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      state   <= IDLE;
      op_r    <= 1'b0;
      err_r   <= 1'b0;
      src_r   <= '0;
      dst_r   <= '0;
      len_r   <= '0;
      i       <= '0;
      lat_cnt <= '0;
      byte_r  <= '0;
    end else begin
      state <= nxt;
      if (state == IDLE && START) begin
        op_r  <= OP;
        src_r <= SRC;
        dst_r <= DST;
        len_r <= LEN;
      end
      if (state == CHECK) begin
        err_r   <= bad;
        i       <= '0;
        lat_cnt <= '0;
      end
      if (state == RD) begin
        lat_cnt <= lat_cnt + CW'(1);
        if (last) byte_r <= MEM_RDATA;
      end
      if (state == WR) begin
        i       <= i + ADDR_W'(1);
        lat_cnt <= '0;
      end
    end
  always_comb begin
    nxt         = IDLE;
    BUSY        = state != IDLE;
    DONE        = state == FIN;
    ERR         = state == FIN && err_r;
    MEM_READ    = state == RD;
    MEM_WRITE   = state == WR;
    MEM_ADDRESS = MEM_READ ? rd_addr[ADDR_W-1:0] : MEM_WRITE ? wr_addr[ADDR_W-1:0] : '0;
    MEM_WDATA   = MEM_WRITE ? (op_r ? -byte_r : byte_r) : '0;
    case (state)
      IDLE:    nxt = START ? CHECK : IDLE;
      CHECK:   nxt = bad || len_r == '0 ? FIN : RD;
      RD:      nxt = last ? WR : RD;
      WR:      nxt = i + ADDR_W'(1) == len_r ? FIN : RD;
      default: nxt = IDLE;
    endcase
  end
endmodule

// File: tb/tb_dmem_block_mover.sv
// tb_dmem_block_mover: drives two movers (read latency 1 and 3) against behavioural memories and a block-transfer model
module tb_dmem_block_mover;
  logic CLK = 1'b0, RST = 1'b1;
  logic [1:0] start, op, preload, busy, done, err, mrd, mwr;
  logic [1:0][7:0] src, dst, len, maddr, mwd, mrdata;
  logic [7:0] mem [2][32];
  logic [7:0] ref_mem [2][32];
  int rcnt [2];
  int checks = 0, failures = 0;
  int exp_q[$], tr_q[$];
  int lat, ndone, cyc, bad, exp_lat;
  logic e, exp_err;

  always #5 CLK = ~CLK;

  function automatic int lat_of(int u);
    return u == 0 ? 1 : 3;
  endfunction
  function automatic logic [7:0] init_val(int k);
    return k < 16 ? 8'(k) : 8'(-(k - 16));
  endfunction
  function automatic int rd_ev(int a);
    return (1 << 16) | (a << 8);
  endfunction
  function automatic int wr_ev(int a, logic [7:0] v);
    return (2 << 16) | (a << 8) | int'(v);
  endfunction
  function automatic bit trace_ok();
    if (tr_q.size() != exp_q.size()) return 0;
    foreach (tr_q[k]) if (tr_q[k] != exp_q[k]) return 0;
    return 1;
  endfunction
  function automatic bit mem_ok(int u);
    for (int k = 0; k < 32; k++) if (mem[u][k] !== ref_mem[u][k]) return 0;
    return 1;
  endfunction

  dmem_block_mover #(.READ_LAT(1)) dut0 (
    .CLK(CLK), .RST(RST), .START(start[0]), .OP(op[0]), .SRC(src[0]), .DST(dst[0]), .LEN(len[0]),
    .BUSY(busy[0]), .DONE(done[0]), .ERR(err[0]), .MEM_READ(mrd[0]), .MEM_WRITE(mwr[0]),
    .MEM_ADDRESS(maddr[0]), .MEM_WDATA(mwd[0]), .MEM_RDATA(mrdata[0]));
  dmem_block_mover #(.READ_LAT(3)) dut1 (
    .CLK(CLK), .RST(RST), .START(start[1]), .OP(op[1]), .SRC(src[1]), .DST(dst[1]), .LEN(len[1]),
    .BUSY(busy[1]), .DONE(done[1]), .ERR(err[1]), .MEM_READ(mrd[1]), .MEM_WRITE(mwr[1]),
    .MEM_ADDRESS(maddr[1]), .MEM_WDATA(mwd[1]), .MEM_RDATA(mrdata[1]));

  // read data only becomes valid once the strobe has been held for the instance's latency
  always @(posedge CLK)
    for (int g = 0; g < 2; g++) begin
      rcnt[g] <= mrd[g] ? rcnt[g] + 1 : 0;
      if (preload[g]) for (int k = 0; k < 32; k++) mem[g][k] <= init_val(k);
      else if (mwr[g] && maddr[g] < 8'd32) mem[g][maddr[g][4:0]] <= mwd[g];
    end
  always_comb
    for (int g = 0; g < 2; g++)
      mrdata[g] = (mrd[g] && rcnt[g] >= lat_of(g) - 1 && maddr[g] < 8'd32) ? mem[g][maddr[g][4:0]] : 8'hA5;

  task automatic do_preload();
    preload = 2'b11;
    @(negedge CLK);
    preload = 2'b00;
    for (int u = 0; u < 2; u++) for (int k = 0; k < 32; k++) ref_mem[u][k] = init_val(k);
  endtask

  task automatic model(input int u, input logic o, input int s, input int d, input int l,
                       output int xl, output logic xe);
    logic [7:0] b;
    exp_q.delete();
    xe = s >= 32 || d >= 32 || l > 32;
    xl = (xe || l == 0) ? 1 : 1 + l * (lat_of(u) + 1);
    if (!xe)
      for (int k = 0; k < l; k++) begin
        b = ref_mem[u][(s + k) % 32];
        if (o) b = -b;
        ref_mem[u][(d + k) % 32] = b;
        exp_q.push_back(rd_ev((s + k) % 32));
        exp_q.push_back(wr_ev((d + k) % 32, b));
      end
  endtask

  task automatic run(input int u, input logic o, input int s, input int d, input int l, input int pulse_at,
                     output int lt, output int nd, output int cy, output logic er, output int bd);
    logic prev_rd = 1'b0;
    logic [7:0] prev_addr = 8'h00;
    tr_q.delete();
    lt = -1; nd = 0; cy = 0; er = 1'b0; bd = 0;
    @(negedge CLK);
    op[u] = o; src[u] = 8'(s); dst[u] = 8'(d); len[u] = 8'(l); start[u] = 1'b1;
    @(negedge CLK);
    start[u] = 1'b0;
    for (int n = 1; n < 400 && busy[u]; n++) begin
      cy++;
      if (done[u]) begin
        nd++;
        if (lt < 0) lt = n - 1;
        er = err[u];
      end
      if (mrd[u] && mwr[u]) bd++;
      if (!mrd[u] && !mwr[u] && (maddr[u] != 8'h00 || mwd[u] != 8'h00)) bd++;
      if (mrd[u] && prev_rd && maddr[u] != prev_addr) bd++;
      if (mwr[u]) tr_q.push_back(wr_ev(int'(maddr[u]), mwd[u]));
      else if (mrd[u] && !prev_rd) tr_q.push_back(rd_ev(int'(maddr[u])));
      prev_rd = mrd[u];
      prev_addr = maddr[u];
      if (n == pulse_at) begin
        start[u] = 1'b1; op[u] = ~o;
        src[u] = 8'($urandom_range(31)); dst[u] = 8'($urandom_range(31)); len[u] = 8'($urandom_range(32, 1));
      end
      @(negedge CLK);
      start[u] = 1'b0;
    end
    if (busy[u]) lt = -2;
  endtask

  task automatic test_reset();
    @(negedge CLK);
    checks++;
    if ({busy, done, err, mrd, mwr} !== 10'b0) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=0", {busy, done, err, mrd, mwr});
    end
    checks++;
    if ({maddr, mwd} !== 32'h0) begin
      failures++;
      $display("FAIL reset_bus got=%h exp=0", {maddr, mwd});
    end
  endtask

  task automatic test_copy();
    for (int u = 0; u < 2; u++) begin
      do_preload();
      run(u, 1'b0, 2, 20, 3, 0, lat, ndone, cyc, e, bad);
      checks++;
      if (lat !== (u == 0 ? 7 : 13)) begin
        failures++;
        $display("FAIL copy_latency u=%0d got=%0d exp=%0d", u, lat, u == 0 ? 7 : 13);
      end
      checks++;
      if ({mem[u][20], mem[u][21], mem[u][22]} !== 24'h020304) begin
        failures++;
        $display("FAIL copy_data u=%0d got=%h exp=020304", u, {mem[u][20], mem[u][21], mem[u][22]});
      end
      checks++;
      if (ndone != 1 || e !== 1'b0) begin
        failures++;
        $display("FAIL copy_done u=%0d got done=%0d err=%b exp done=1 err=0", u, ndone, e);
      end
    end
  endtask

  task automatic test_negate();
    do_preload();
    run(0, 1'b1, 5, 8, 2, 0, lat, ndone, cyc, e, bad);
    exp_q = '{rd_ev(5), wr_ev(8, 8'hFB), rd_ev(6), wr_ev(9, 8'hFA)};
    checks++;
    if (!trace_ok()) begin
      failures++;
      $display("FAIL negate_trace got=%p exp=%p", tr_q, exp_q);
    end
    checks++;
    if ({mem[0][8], mem[0][9]} !== 16'hFBFA || bad != 0) begin
      failures++;
      $display("FAIL negate_data got=%h bus_violations=%0d exp=FBFA 0", {mem[0][8], mem[0][9]}, bad);
    end
  endtask

  task automatic test_wrap();
    do_preload();
    run(0, 1'b0, 30, 0, 4, 0, lat, ndone, cyc, e, bad);
    exp_q = '{rd_ev(30), wr_ev(0, 8'hF2), rd_ev(31), wr_ev(1, 8'hF1),
              rd_ev(0), wr_ev(2, 8'hF2), rd_ev(1), wr_ev(3, 8'hF1)};
    checks++;
    if (!trace_ok()) begin
      failures++;
      $display("FAIL wrap_trace got=%p exp=%p", tr_q, exp_q);
    end
    checks++;
    if ({mem[0][0], mem[0][1], mem[0][2], mem[0][3]} !== 32'hF2F1F2F1) begin
      failures++;
      $display("FAIL wrap_data got=%h exp=F2F1F2F1", {mem[0][0], mem[0][1], mem[0][2], mem[0][3]});
    end
  endtask

  task automatic test_reject();
    int s [3] = '{3, 40, 2};
    int l [3] = '{0, 2, 33};
    for (int k = 0; k < 3; k++) begin
      run(0, 1'b0, s[k], 10, l[k], 0, lat, ndone, cyc, e, bad);
      checks++;
      if (lat != 1 || cyc != 2 || ndone != 1 || e !== (k != 0) || tr_q.size() != 0) begin
        failures++;
        $display("FAIL reject_%0d got lat=%0d cyc=%0d done=%0d err=%b strobes=%0d exp lat=1 cyc=2 done=1 err=%b strobes=0",
                 k, lat, cyc, ndone, e, tr_q.size(), k != 0);
      end
    end
  endtask

  task automatic test_start_ignored();
    do_preload();
    model(1, 1'b1, 12, 25, 5, exp_lat, exp_err);
    run(1, 1'b1, 12, 25, 5, 3, lat, ndone, cyc, e, bad);
    checks++;
    if (ndone != 1 || lat != exp_lat) begin
      failures++;
      $display("FAIL ignore_done got done=%0d lat=%0d exp done=1 lat=%0d", ndone, lat, exp_lat);
    end
    checks++;
    if (!mem_ok(1) || !trace_ok()) begin
      failures++;
      $display("FAIL ignore_result got trace=%p exp=%p", tr_q, exp_q);
    end
  endtask

  task automatic test_abort();
    bit seen = 0;
    do_preload();
    op[0] = 1'b0; src[0] = 8'd0; dst[0] = 8'd10; len[0] = 8'd4; start[0] = 1'b1;
    @(negedge CLK);
    start[0] = 1'b0;
    for (int n = 0; n < 30 && !seen; n++) begin
      @(negedge CLK);
      seen = mwr[0];
    end
    RST = 1'b1;
    #1;
    checks++;
    if (!seen || {mwr[0], busy[0], done[0]} !== 3'b000) begin
      failures++;
      $display("FAIL abort_now got seen_wr=%0d wr/busy/done=%b exp seen_wr=1 000", seen, {mwr[0], busy[0], done[0]});
    end
    @(negedge CLK);
    checks++;
    if ({busy[0], done[0]} !== 2'b00) begin
      failures++;
      $display("FAIL abort_hold got busy/done=%b exp=00", {busy[0], done[0]});
    end
    RST = 1'b0;
    do_preload();
    model(0, 1'b1, 17, 4, 6, exp_lat, exp_err);
    run(0, 1'b1, 17, 4, 6, 0, lat, ndone, cyc, e, bad);
    checks++;
    if (lat != exp_lat || ndone != 1 || !mem_ok(0)) begin
      failures++;
      $display("FAIL abort_restart got lat=%0d done=%0d mem_ok=%0d exp lat=%0d done=1 mem_ok=1", lat, ndone, mem_ok(0), exp_lat);
    end
  endtask

  task automatic test_random();
    int u, s, d, l;
    logic o;
    for (int it = 0; it < 24; it++) begin
      if (it % 6 == 0) do_preload();
      u = $urandom_range(1);
      o = 1'($urandom_range(1));
      s = $urandom_range(9) == 0 ? $urandom_range(72, 32) : $urandom_range(31);
      d = $urandom_range(9) == 0 ? $urandom_range(72, 32) : $urandom_range(31);
      l = $urandom_range(33);
      model(u, o, s, d, l, exp_lat, exp_err);
      run(u, o, s, d, l, 0, lat, ndone, cyc, e, bad);
      checks++;
      if (lat != exp_lat || ndone != 1) begin
        failures++;
        $display("FAIL rand_timing it=%0d got lat=%0d done=%0d exp lat=%0d done=1", it, lat, ndone, exp_lat);
      end
      checks++;
      if (e !== exp_err) begin
        failures++;
        $display("FAIL rand_err it=%0d got=%b exp=%b", it, e, exp_err);
      end
      checks++;
      if (bad != 0) begin
        failures++;
        $display("FAIL rand_bus it=%0d got violations=%0d exp=0", it, bad);
      end
      checks++;
      if (!trace_ok()) begin
        failures++;
        $display("FAIL rand_trace it=%0d got=%0d events exp=%0d events", it, tr_q.size(), exp_q.size());
      end
      checks++;
      if (!mem_ok(u)) begin
        failures++;
        $display("FAIL rand_mem it=%0d u=%0d got mismatching memory exp model contents", it, u);
      end
    end
  endtask

  initial begin
    start = '0; op = '0; preload = '0; src = '0; dst = '0; len = '0;
    test_reset();
    RST = 1'b0;
    test_copy();
    test_negate();
    test_wrap();
    test_reject();
    test_start_ignored();
    test_abort();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
